// File: rtl/fofb_readout_sequencer.sv
// fofb_readout_sequencer: sysClk-side sweep of the per-BPM X/Y/S DPRAM.
// On each accepted start pulse it walks the BPM indices and emits one
// record per selected BPM on a valid/ready stream.
// Optional feature macro: FOFB_READOUT_MASK_EN
//   defined   -> only indices set in bpmBitmap (and below FOFB_COUNT) are emitted
//   undefined -> bpmBitmap ignored, every index 0..FOFB_COUNT-1 is emitted
module fofb_readout_sequencer #(
  parameter int unsigned FOFB_INDEX_WIDTH = 9,
  parameter int unsigned FOFB_COUNT       = 512
) (
  input  logic                               sysClk,
  input  logic                               sysReset_n,
  input  logic                               start,
  input  logic [(2**FOFB_INDEX_WIDTH)-1:0]   bpmBitmap,
  output logic [FOFB_INDEX_WIDTH-1:0]        readoutAddress,
  input  logic [31:0]                        readoutX,
  input  logic [31:0]                        readoutY,
  input  logic [31:0]                        readoutS,
  output logic                               mValid,
  input  logic                               mReady,
  output logic [FOFB_INDEX_WIDTH-1:0]        mIndex,
  output logic [31:0]                        mX,
  output logic [31:0]                        mY,
  output logic [31:0]                        mS,
  output logic                               mLast,
  output logic                               busy,
  output logic                               sweepDone,
  output logic [15:0]                        overrunCount
);

  localparam int unsigned NBPM = 2**FOFB_INDEX_WIDTH;

  function automatic logic [NBPM-1:0] valid_mask_f();
    logic [NBPM-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NBPM; i++) begin
      if (i < FOFB_COUNT) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [NBPM-1:0] VALID_MASK = valid_mask_f();

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    WAIT,
    LOAD,
    SEND
  } state_t;

  state_t                      state_q;
  logic [FOFB_INDEX_WIDTH-1:0] idx_q;
  logic [NBPM-1:0]             pending_q;
  logic [NBPM-1:0]             pending_clr_d;
  logic [NBPM-1:0]             start_mask_d;
  logic [FOFB_INDEX_WIDTH-1:0] addr_q;
  logic [FOFB_INDEX_WIDTH-1:0] mIndex_q;
  logic [31:0]                 mX_q;
  logic [31:0]                 mY_q;
  logic [31:0]                 mS_q;
  logic                        mValid_q;
  logic                        mLast_q;
  logic                        busy_q;
  logic                        sweepDone_q;
  logic [15:0]                 overrun_q;

`ifdef FOFB_READOUT_MASK_EN
  // Sparse sweep: only BPMs reported this FA cycle are read out
  always_comb begin
    start_mask_d = bpmBitmap & VALID_MASK;
  end
`else
  logic unused_bitmap;
  assign unused_bitmap = ^bpmBitmap;

  // Dense sweep: every valid index is read out regardless of the bitmap
  always_comb begin
    start_mask_d = VALID_MASK;
  end
`endif

  // Pending mask with the current index retired
  always_comb begin
    pending_clr_d        = pending_q;
    pending_clr_d[idx_q] = 1'b0;
  end

  // Sweep FSM, output record registers and overrun counter
  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      pending_q   <= '0;
      addr_q      <= '0;
      mIndex_q    <= '0;
      mX_q        <= '0;
      mY_q        <= '0;
      mS_q        <= '0;
      mValid_q    <= 1'b0;
      mLast_q     <= 1'b0;
      busy_q      <= 1'b0;
      sweepDone_q <= 1'b0;
      overrun_q   <= '0;
    end else begin
      sweepDone_q <= 1'b0;
      if (start && busy_q && (overrun_q != '1)) overrun_q <= overrun_q + 16'd1;
      case (state_q)
        IDLE: begin
          if (start) begin
            pending_q <= start_mask_d;
            idx_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= SCAN;
          end
        end
        SCAN: begin
          if (pending_q == '0) begin
            sweepDone_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else if (pending_q[idx_q]) begin
            addr_q  <= idx_q;
            state_q <= WAIT;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        WAIT: state_q <= LOAD;
        LOAD: begin
          mX_q      <= readoutX;
          mY_q      <= readoutY;
          mS_q      <= readoutS;
          mIndex_q  <= idx_q;
          mValid_q  <= 1'b1;
          mLast_q   <= (pending_clr_d == '0);
          pending_q <= pending_clr_d;
          state_q   <= SEND;
        end
        SEND: begin
          if (mValid_q && mReady) begin
            mValid_q <= 1'b0;
            mLast_q  <= 1'b0;
            if (mLast_q) begin
              sweepDone_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= IDLE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= SCAN;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign readoutAddress = addr_q;
  assign mValid         = mValid_q;
  assign mIndex         = mIndex_q;
  assign mX             = mX_q;
  assign mY             = mY_q;
  assign mS             = mS_q;
  assign mLast          = mLast_q;
  assign busy           = busy_q;
  assign sweepDone      = sweepDone_q;
  assign overrunCount   = overrun_q;

endmodule

// File: tb/tb_fofb_readout_sequencer.sv
// Directed bench for fofb_readout_sequencer (W=4, FOFB_COUNT=8).
// Honours FOFB_READOUT_MASK_EN the same way the design does.
module tb_fofb_readout_sequencer;

  localparam int unsigned W = 4;
  localparam int unsigned N = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [15:0]      bpmBitmap;
  logic [W-1:0]     readoutAddress;
  logic [31:0]      rdX, rdY, rdS;
  logic             mValid, mReady, mLast, busy, sweepDone;
  logic [W-1:0]     mIndex;
  logic [31:0]      mX, mY, mS;
  logic [15:0]      overrunCount;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  fofb_readout_sequencer #(
    .FOFB_INDEX_WIDTH(W),
    .FOFB_COUNT      (N)
  ) dut (
    .sysClk        (clk),
    .sysReset_n    (rst_n),
    .start         (start),
    .bpmBitmap     (bpmBitmap),
    .readoutAddress(readoutAddress),
    .readoutX      (rdX),
    .readoutY      (rdY),
    .readoutS      (rdS),
    .mValid        (mValid),
    .mReady        (mReady),
    .mIndex        (mIndex),
    .mX            (mX),
    .mY            (mY),
    .mS            (mS),
    .mLast         (mLast),
    .busy          (busy),
    .sweepDone     (sweepDone),
    .overrunCount  (overrunCount)
  );

  // DPRAM model with registered read: X=idx, Y=~idx, S=5000_0000|idx
  always @(posedge clk) begin
    rdX <= {28'd0, readoutAddress};
    rdY <= ~{28'd0, readoutAddress};
    rdS <= 32'h5000_0000 | {28'd0, readoutAddress};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One sweep against exp_q. stall: cycles mReady held low on first record;
  // pulses: three start pulses during that stall; end_start: start on the final accept edge.
  task automatic sweep(input string tag, input logic [15:0] bm, input int stall,
                       input bit pulses, input bit end_start);
    int lat;
    int e;
    int gap;
    bpmBitmap = bm;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
    lat = 0;
    if (exp_q.size() == 0) begin
      tick();
      check({tag, "_empty_done"}, {31'd0, sweepDone}, 32'd1);
      check({tag, "_empty_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_empty_valid"}, {31'd0, mValid}, 32'd0);
    end
    for (int r = 0; r < exp_q.size(); r++) begin
      e = exp_q[r];
      while (mValid !== 1'b1 && lat < 40) begin
        tick();
        lat++;
      end
      gap = (r == 0) ? 3 + e : 3 + e - exp_q[r-1];
      check({tag, "_latency"}, lat, gap);
      check({tag, "_idx"}, {28'd0, mIndex}, e);
      check({tag, "_x"}, mX, 32'(e));
      check({tag, "_y"}, mY, ~32'(e));
      check({tag, "_s"}, mS, 32'h5000_0000 | 32'(e));
      check({tag, "_last"}, {31'd0, mLast}, (r == exp_q.size() - 1) ? 32'd1 : 32'd0);
      check({tag, "_addr"}, {28'd0, readoutAddress}, e);
      if (r == 0 && stall > 0) begin
        mReady = 1'b0;
        for (int s = 1; s <= stall; s++) begin
          if (pulses && (s == 2 || s == 5 || s == 8)) start = 1'b1;
          tick();
          start = 1'b0;
          check({tag, "_hold_valid"}, {31'd0, mValid}, 32'd1);
          check({tag, "_hold_idx"}, {28'd0, mIndex}, e);
          check({tag, "_hold_x"}, mX, 32'(e));
          check({tag, "_hold_addr"}, {28'd0, readoutAddress}, e);
        end
        mReady = 1'b1;
      end
      if (r == exp_q.size() - 1 && end_start) start = 1'b1;
      tick();
      start = 1'b0;
      lat = 1;
      check({tag, "_accept_valid"}, {31'd0, mValid}, 32'd0);
    end
    if (exp_q.size() != 0) begin
      check({tag, "_done"}, {31'd0, sweepDone}, 32'd1);
      check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    end
    tick();
    check({tag, "_done_pulse"}, {31'd0, sweepDone}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic set_expect_sparse();
    exp_q.delete();
`ifdef FOFB_READOUT_MASK_EN
    exp_q.push_back(3);
    exp_q.push_back(7);
`else
    for (int i = 0; i < int'(N); i++) exp_q.push_back(i);
`endif
  endtask

  task automatic set_expect_empty();
    exp_q.delete();
`ifndef FOFB_READOUT_MASK_EN
    for (int i = 0; i < int'(N); i++) exp_q.push_back(i);
`endif
  endtask

  task automatic set_expect_pair();
    exp_q.delete();
`ifdef FOFB_READOUT_MASK_EN
    exp_q.push_back(0);
    exp_q.push_back(1);
`else
    for (int i = 0; i < int'(N); i++) exp_q.push_back(i);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bpmBitmap = '0;
    mReady = 1'b1;
    #2;
    check("rst_valid", {31'd0, mValid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_addr", {28'd0, readoutAddress}, 32'd0);
    check("rst_idx", {28'd0, mIndex}, 32'd0);
    check("rst_x", mX, 32'd0);
    check("rst_last", {31'd0, mLast}, 32'd0);
    check("rst_done", {31'd0, sweepDone}, 32'd0);
    check("rst_ovr", {16'd0, overrunCount}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Bits 3, 7 and 12; 12 lies beyond FOFB_COUNT and must be dropped
    set_expect_sparse();
    sweep("sparse", 16'h1088, 0, 1'b0, 1'b0);

    set_expect_empty();
    sweep("empty", 16'h0000, 0, 1'b0, 1'b0);

    set_expect_pair();
    sweep("bp", 16'h0003, 10, 1'b0, 1'b0);
    check("bp_ovr", {16'd0, overrunCount}, 32'd0);

    set_expect_pair();
    sweep("ovr", 16'h0003, 10, 1'b1, 1'b1);
    check("ovr_count", {16'd0, overrunCount}, 32'd4);

    // Asynchronous reset in the middle of a stalled record
    set_expect_pair();
    bpmBitmap = 16'h0003;
    start = 1'b1;
    tick();
    start = 1'b0;
    mReady = 1'b0;
    repeat (6) tick();
    check("midrst_pre_valid", {31'd0, mValid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, mValid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_addr", {28'd0, readoutAddress}, 32'd0);
    check("midrst_ovr", {16'd0, overrunCount}, 32'd0);
    mReady = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    sweep("postrst", 16'h0003, 0, 1'b0, 1'b0);

    // Saturation: stall a sweep and hold start high
    bpmBitmap = 16'h0003;
    start = 1'b1;
    tick();
    mReady = 1'b0;
    repeat (100) tick();
    check("sat_mid", {16'd0, overrunCount}, 32'd100);
    repeat (65500) tick();
    check("sat_full", {16'd0, overrunCount}, 32'h0000_FFFF);
    tick();
    check("sat_hold", {16'd0, overrunCount}, 32'h0000_FFFF);
    start = 1'b0;
    mReady = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
